// File: rtl/pipe_run_ctrl.sv
// Run sequencer and performance monitor for the pipelined MIPS core (reset, run, drain, done).
// Define PIPE_RUN_CTRL_TRACE_EN to build the registered writeback trace port.
module pipe_run_ctrl #(
   parameter int unsigned RST_CYCLES   = 2,
   parameter int unsigned PC_W         = 32,
   parameter int unsigned CNT_W        = 32,
   parameter logic [31:0] HALT_INSTR   = 32'h0000000C,
   parameter int unsigned DRAIN_CYCLES = 4,
   parameter int unsigned LOOP_WINDOW  = 8,
   parameter int unsigned MAX_CYCLES   = 100000
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              START,
   input  logic [PC_W-1:0]   PC,
   input  logic              PCWrite,
   input  logic              IF_Flush,
   input  logic [31:0]       IF_Instruction,
   input  logic              WB_Valid,
   input  logic [4:0]        WB_RD,
   input  logic [31:0]       WB_RD_DATA,
   output logic              CORE_RESET,
   output logic              BUSY,
   output logic              DONE,
   output logic              TIMEOUT,
   output logic              LOOP_HALT,
   output logic [CNT_W-1:0]  CYCLES,
   output logic [CNT_W-1:0]  RETIRED,
   output logic [CNT_W-1:0]  STALLS,
   output logic [CNT_W-1:0]  FLUSHES,
   output logic              TRACE_VALID,
   output logic [4:0]        TRACE_RD,
   output logic [31:0]       TRACE_DATA
);

   localparam int unsigned WAIT_MAX = (RST_CYCLES > DRAIN_CYCLES) ? RST_CYCLES : DRAIN_CYCLES;
   localparam int unsigned WAIT_W   = $clog2(WAIT_MAX + 1);
   localparam int unsigned LOOP_W   = $clog2(LOOP_WINDOW + 1);

   typedef enum logic [2:0] {S_IDLE, S_RST, S_RUN, S_DRAIN, S_DONE} state_t;

   state_t              r_state, w_state_nxt;
   logic [WAIT_W-1:0]   r_wait;
   logic [LOOP_W-1:0]   r_loop, w_loop_nxt;
   logic [PC_W-1:0]     r_prev_pc;
   logic [CNT_W-1:0]    r_cycles, r_retired, r_stalls, r_flushes;
   logic                r_to_flag, r_lh_flag;
   logic                r_core_reset, r_busy, r_done, r_timeout, r_loop_halt;
   logic                w_clear, w_set_to, w_set_loop, w_active, w_budget_hit, w_halt;

   function automatic logic [CNT_W-1:0] f_sat_inc(input logic [CNT_W-1:0] v, input logic en);
      return (en && (v != '1)) ? v + CNT_W'(1) : v;
   endfunction

   assign w_active     = (r_state == S_RUN) || (r_state == S_DRAIN);
   assign w_budget_hit = (r_cycles == CNT_W'(MAX_CYCLES - 1));
   assign w_halt       = (IF_Instruction == HALT_INSTR) && PCWrite;
   assign w_loop_nxt   = (PCWrite && (PC == r_prev_pc)) ? r_loop + LOOP_W'(1) : LOOP_W'(1);

   always_comb begin
      w_state_nxt = r_state;
      w_clear     = 1'b0;
      w_set_to    = 1'b0;
      w_set_loop  = 1'b0;
      case (r_state)
         S_IDLE, S_DONE: begin
            if (START) begin
               w_state_nxt = S_RST;
               w_clear     = 1'b1;
            end
         end
         S_RST: begin
            if (r_wait == WAIT_W'(RST_CYCLES - 1)) w_state_nxt = S_RUN;
         end
         S_RUN: begin
            if (w_budget_hit) begin
               w_state_nxt = S_DONE;
               w_set_to    = 1'b1;
            end else if (w_halt) begin
               w_state_nxt = S_DRAIN;
            end else if (w_loop_nxt == LOOP_W'(LOOP_WINDOW)) begin
               w_state_nxt = S_DONE;
               w_set_loop  = 1'b1;
            end
         end
         S_DRAIN: begin
            if (w_budget_hit) begin
               w_state_nxt = S_DONE;
               w_set_to    = 1'b1;
            end else if (r_wait == WAIT_W'(DRAIN_CYCLES - 1)) begin
               w_state_nxt = S_DONE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // r_wait restarts on every state change, so it times both RST and DRAIN.
   always_ff @(posedge CLK) begin
      if (!RESET) begin
         r_state   <= S_IDLE;
         r_wait    <= '0;
         r_loop    <= LOOP_W'(1);
         r_prev_pc <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_wait    <= (w_state_nxt != r_state) ? '0 : r_wait + WAIT_W'(1);
         r_loop    <= (r_state == S_RUN) ? w_loop_nxt : LOOP_W'(1);
         r_prev_pc <= PC;
      end
   end

   always_ff @(posedge CLK) begin
      if (!RESET || w_clear) begin
         r_cycles  <= '0;
         r_retired <= '0;
         r_stalls  <= '0;
         r_flushes <= '0;
         r_to_flag <= 1'b0;
         r_lh_flag <= 1'b0;
      end else begin
         if (w_active) begin
            r_cycles  <= f_sat_inc(r_cycles, 1'b1);
            r_retired <= f_sat_inc(r_retired, WB_Valid);
            r_stalls  <= f_sat_inc(r_stalls, !PCWrite);
            r_flushes <= f_sat_inc(r_flushes, IF_Flush);
         end
         if (w_set_to)   r_to_flag <= 1'b1;
         if (w_set_loop) r_lh_flag <= 1'b1;
      end
   end

   // Status outputs follow the registered state, so they trail a state change by one cycle.
   always_ff @(posedge CLK) begin
      if (!RESET) begin
         r_core_reset <= 1'b1;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_timeout    <= 1'b0;
         r_loop_halt  <= 1'b0;
      end else begin
         r_core_reset <= (r_state == S_IDLE) || (r_state == S_RST);
         r_busy       <= (r_state == S_RST) || w_active;
         r_done       <= (r_state == S_DONE);
         r_timeout    <= r_to_flag;
         r_loop_halt  <= r_lh_flag;
      end
   end

   assign CORE_RESET = r_core_reset;
   assign BUSY       = r_busy;
   assign DONE       = r_done;
   assign TIMEOUT    = r_timeout;
   assign LOOP_HALT  = r_loop_halt;
   assign CYCLES     = r_cycles;
   assign RETIRED    = r_retired;
   assign STALLS     = r_stalls;
   assign FLUSHES    = r_flushes;

`ifdef PIPE_RUN_CTRL_TRACE_EN
   logic        r_trace_valid;
   logic [4:0]  r_trace_rd;
   logic [31:0] r_trace_data;

   always_ff @(posedge CLK) begin
      if (!RESET) begin
         r_trace_valid <= 1'b0;
         r_trace_rd    <= '0;
         r_trace_data  <= '0;
      end else if (w_active && WB_Valid && (WB_RD != 5'd0)) begin
         r_trace_valid <= 1'b1;
         r_trace_rd    <= WB_RD;
         r_trace_data  <= WB_RD_DATA;
      end else begin
         r_trace_valid <= 1'b0;
         r_trace_rd    <= '0;
         r_trace_data  <= '0;
      end
   end

   assign TRACE_VALID = r_trace_valid;
   assign TRACE_RD    = r_trace_rd;
   assign TRACE_DATA  = r_trace_data;
`else
   logic w_unused_trace;
   assign w_unused_trace = ^{WB_RD, WB_RD_DATA};
   assign TRACE_VALID    = 1'b0;
   assign TRACE_RD       = '0;
   assign TRACE_DATA     = '0;
`endif

endmodule

// File: tb/tb_pipe_run_ctrl.sv
// Bench for pipe_run_ctrl: directed scenarios plus random runs against a per-run reference model.
module tb_pipe_run_ctrl;

   localparam int unsigned RST_N  = 2;
   localparam int unsigned DRAIN  = 4;
   localparam int unsigned WINDOW = 8;
   localparam int unsigned MAXC   = 20;
   localparam int unsigned MAXK   = MAXC;
   localparam logic [31:0] HALT   = 32'h0000000C;
   localparam logic [31:0] SENT   = 32'hFFFF_FFF0;

   logic        CLK = 1'b0;
   logic        RESET, START, PCWrite, IF_Flush, WB_Valid;
   logic [31:0] PC, IF_Instruction, WB_RD_DATA;
   logic [4:0]  WB_RD;
   logic        CORE_RESET, BUSY, DONE, TIMEOUT, LOOP_HALT, TRACE_VALID;
   logic [31:0] CYCLES, RETIRED, STALLS, FLUSHES, TRACE_DATA;
   logic [4:0]  TRACE_RD;

   int unsigned n_vec = 0;
   int unsigned n_err = 0;
   bit          from_idle;

   bit          s_pcw [0:MAXK];
   bit          s_fl  [0:MAXK];
   bit          s_wbv [0:MAXK];
   logic [4:0]  s_rd  [0:MAXK];
   logic [31:0] s_data[0:MAXK];
   logic [31:0] s_ins [0:MAXK];
   logic [31:0] s_pc  [0:MAXK];
   int unsigned e_cyc [0:MAXK];
   int unsigned e_ret [0:MAXK];
   int unsigned e_st  [0:MAXK];
   int unsigned e_fl  [0:MAXK];

   pipe_run_ctrl #(
      .RST_CYCLES(RST_N), .PC_W(32), .CNT_W(32), .HALT_INSTR(HALT),
      .DRAIN_CYCLES(DRAIN), .LOOP_WINDOW(WINDOW), .MAX_CYCLES(MAXC)
   ) dut (
      .CLK(CLK), .RESET(RESET), .START(START), .PC(PC), .PCWrite(PCWrite),
      .IF_Flush(IF_Flush), .IF_Instruction(IF_Instruction), .WB_Valid(WB_Valid),
      .WB_RD(WB_RD), .WB_RD_DATA(WB_RD_DATA), .CORE_RESET(CORE_RESET), .BUSY(BUSY),
      .DONE(DONE), .TIMEOUT(TIMEOUT), .LOOP_HALT(LOOP_HALT), .CYCLES(CYCLES),
      .RETIRED(RETIRED), .STALLS(STALLS), .FLUSHES(FLUSHES), .TRACE_VALID(TRACE_VALID),
      .TRACE_RD(TRACE_RD), .TRACE_DATA(TRACE_DATA)
   );

   always #5 CLK = ~CLK;

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_cnt(input int unsigned c, input int unsigned r, input int unsigned s, input int unsigned f);
      chk("CYCLES", CYCLES, c);
      chk("RETIRED", RETIRED, r);
      chk("STALLS", STALLS, s);
      chk("FLUSHES", FLUSHES, f);
   endtask

   task automatic chk_trace(input bit v, input logic [4:0] rd, input logic [31:0] d);
`ifdef PIPE_RUN_CTRL_TRACE_EN
      chk("TRACE_VALID", TRACE_VALID, v);
      if (v) begin
         chk("TRACE_RD", TRACE_RD, rd);
         chk("TRACE_DATA", TRACE_DATA, d);
      end
`else
      chk("TRACE_VALID_off", TRACE_VALID, 0);
      chk("TRACE_RD_off", TRACE_RD, 0);
      chk("TRACE_DATA_off", TRACE_DATA, 0);
`endif
   endtask

   task automatic drive_idle();
      PC = SENT; PCWrite = 1'b1; IF_Flush = 1'b0; IF_Instruction = 32'h0;
      WB_Valid = 1'b0; WB_RD = 5'd0; WB_RD_DATA = 32'h0;
   endtask

   task automatic drive_k(input int unsigned k);
      PC = s_pc[k]; PCWrite = s_pcw[k]; IF_Flush = s_fl[k]; IF_Instruction = s_ins[k];
      WB_Valid = s_wbv[k]; WB_RD = s_rd[k]; WB_RD_DATA = s_data[k];
   endtask

   task automatic gen_base();
      s_pc[0] = SENT;
      for (int unsigned k = 1; k <= MAXK; k++) begin
         s_pcw[k] = 1'b1; s_fl[k] = 1'b0; s_wbv[k] = 1'b0; s_rd[k] = 5'd0;
         s_data[k] = 32'h0; s_ins[k] = 32'h00000020;
         s_pc[k] = 32'h400 + 32'(4 * (k - 1));
      end
   endtask

   task automatic gen_rand(input bit loopy);
      gen_base();
      for (int unsigned k = 1; k <= MAXK; k++) begin
         s_pcw[k]  = ($urandom_range(0, 4) != 0);
         s_fl[k]   = ($urandom_range(0, 5) == 0);
         s_wbv[k]  = 1'($urandom_range(0, 1));
         s_rd[k]   = 5'($urandom_range(0, 31));
         s_data[k] = $urandom;
         s_ins[k]  = $urandom;
         if (s_ins[k] == HALT) s_ins[k] = 32'h0;
         if (!loopy && ($urandom_range(0, 11) == 0)) s_ins[k] = HALT;
         if (k > 1) s_pc[k] = ($urandom_range(0, 9) < (loopy ? 9 : 2)) ? s_pc[k-1] : s_pc[k-1] + 32'd4;
      end
   endtask

   // Walks the run cycle by cycle applying the documented end-of-run rules; reason 0=halt, 1=budget, 2=loop.
   task automatic model(output int unsigned end_k, output int unsigned reason);
      int unsigned cyc, ret, st, fl, loopc, dleft;
      bit drain, to_hit;
      cyc = 0; ret = 0; st = 0; fl = 0; loopc = 1; dleft = 0; drain = 0;
      end_k = MAXK; reason = 1;
      for (int unsigned k = 1; k <= MAXK; k++) begin
         to_hit = (cyc == MAXC - 1);
         cyc += 1; ret += s_wbv[k]; st += !s_pcw[k]; fl += s_fl[k];
         e_cyc[k] = cyc; e_ret[k] = ret; e_st[k] = st; e_fl[k] = fl;
         loopc = (s_pcw[k] && (s_pc[k] == s_pc[k-1])) ? loopc + 1 : 1;
         if (to_hit) begin
            end_k = k; reason = 1; break;
         end
         if (drain) begin
            dleft -= 1;
            if (dleft == 0) begin
               end_k = k; reason = 0; break;
            end
         end else if ((s_ins[k] == HALT) && s_pcw[k]) begin
            drain = 1; dleft = DRAIN;
         end else if (loopc >= WINDOW) begin
            end_k = k; reason = 2; break;
         end
      end
   endtask

   task automatic run_prog(input int unsigned abort_at);
      int unsigned end_k, reason;
      model(end_k, reason);
      drive_idle();
      START = 1'b1;
      tick();
      START = 1'b0;
      chk("start_busy", BUSY, 0);
      chk("start_core_reset", CORE_RESET, from_idle ? 32'd1 : 32'd0);
      chk_cnt(0, 0, 0, 0);
      for (int unsigned i = 1; i <= RST_N; i++) begin
         START = 1'($urandom_range(0, 1));
         tick();
         chk("rst_busy", BUSY, 1);
         chk("rst_core_reset", CORE_RESET, 1);
         chk("rst_done", DONE, 0);
      end
      for (int unsigned k = 1; k <= end_k; k++) begin
         drive_k(k);
         START = 1'($urandom_range(0, 1));
         if (k == abort_at) RESET = 1'b0;
         tick();
         if (k == abort_at) begin
            chk("abort_core_reset", CORE_RESET, 1);
            chk("abort_busy", BUSY, 0);
            chk("abort_done", DONE, 0);
            chk("abort_flags", {TIMEOUT, LOOP_HALT}, 0);
            chk_cnt(0, 0, 0, 0);
            chk_trace(0, 5'd0, 32'h0);
            RESET = 1'b1; START = 1'b0;
            drive_idle();
            tick();
            chk("idle_core_reset", CORE_RESET, 1);
            chk("idle_busy", BUSY, 0);
            from_idle = 1'b1;
            return;
         end
         chk("run_core_reset", CORE_RESET, 0);
         chk("run_busy", BUSY, 1);
         chk("run_done", DONE, 0);
         chk("run_flags", {TIMEOUT, LOOP_HALT}, 0);
         chk_cnt(e_cyc[k], e_ret[k], e_st[k], e_fl[k]);
         chk_trace(s_wbv[k] && (s_rd[k] != 5'd0), s_rd[k], s_data[k]);
      end
      START = 1'b0;
      drive_idle();
      tick();
      chk("end_done", DONE, 1);
      chk("end_busy", BUSY, 0);
      chk("end_core_reset", CORE_RESET, 0);
      chk("end_timeout", TIMEOUT, (reason == 1) ? 32'd1 : 32'd0);
      chk("end_loop_halt", LOOP_HALT, (reason == 2) ? 32'd1 : 32'd0);
      chk_cnt(e_cyc[end_k], e_ret[end_k], e_st[end_k], e_fl[end_k]);
      chk_trace(0, 5'd0, 32'h0);
      for (int unsigned i = 0; i < 2; i++) begin
         PC = 32'h40; PCWrite = 1'($urandom_range(0, 1)); IF_Flush = 1'b1;
         IF_Instruction = HALT; WB_Valid = 1'b1; WB_RD = 5'd7; WB_RD_DATA = $urandom;
         tick();
         chk("frozen_done", DONE, 1);
         chk("frozen_core_reset", CORE_RESET, 0);
         chk_cnt(e_cyc[end_k], e_ret[end_k], e_st[end_k], e_fl[end_k]);
         chk_trace(0, 5'd0, 32'h0);
      end
      from_idle = 1'b0;
   endtask

   initial begin
      RESET = 1'b0; START = 1'b0;
      drive_idle();
      tick();
      tick();
      chk("reset_core_reset", CORE_RESET, 1);
      chk("reset_busy", BUSY, 0);
      chk("reset_done", DONE, 0);
      chk("reset_flags", {TIMEOUT, LOOP_HALT}, 0);
      chk_cnt(0, 0, 0, 0);
      chk_trace(0, 5'd0, 32'h0);
      RESET = 1'b1;
      from_idle = 1'b1;

      // ten writebacks (r5 <= DEADBEEF first, one to r0), then the halt word
      gen_base();
      for (int unsigned k = 1; k <= 10; k++) begin
         s_wbv[k] = 1'b1; s_rd[k] = 5'(k); s_data[k] = 32'(k * 32'h111);
      end
      s_rd[1] = 5'd5; s_data[1] = 32'hDEADBEEF;
      s_rd[2] = 5'd0;
      s_ins[11] = HALT;
      run_prog(0);

      // three stall cycles (one carrying a halt word) and two flushes
      gen_base();
      s_pcw[3] = 1'b0; s_pcw[4] = 1'b0; s_pcw[5] = 1'b0;
      s_ins[4] = HALT;
      s_fl[2] = 1'b1; s_fl[7] = 1'b1;
      s_ins[9] = HALT;
      run_prog(0);

      // PC parked at 0x40
      gen_base();
      for (int unsigned k = 3; k <= MAXK; k++) s_pc[k] = 32'h40;
      run_prog(0);

      // halt word on the last budgeted cycle
      gen_base();
      s_ins[20] = HALT;
      run_prog(0);

      // budget expires while draining; a second halt word is ignored
      gen_base();
      s_ins[17] = HALT; s_ins[18] = HALT;
      run_prog(0);

      // reset mid-run, then a clean restart
      gen_base();
      s_ins[12] = HALT;
      for (int unsigned k = 1; k <= 4; k++) s_wbv[k] = 1'b1;
      run_prog(5);
      gen_base();
      s_wbv[2] = 1'b1; s_rd[2] = 5'd3; s_data[2] = 32'hCAFE0001;
      s_ins[6] = HALT;
      run_prog(0);

      for (int unsigned n = 0; n < 12; n++) begin
         gen_rand(n[0]);
         run_prog(0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/pipe_run_ctrl.md
# pipe_run_ctrl

Parametrised run controller and performance monitor for the pipelined MIPS core. It replaces fixed-delay reset/run sequencing with a state machine that:
- drives the core reset for a configurable number of cycles;
- counts cycles, retired writebacks, stalls and flushes;
- detects program end via a halt instruction, a PC self-loop or a cycle budget.

It sits between the bench (or board-level control) and the pipeline top, observing the IF and WB stages.

## Interface
Parameters:
- RST_CYCLES, 2: cycles CORE_RESET is held high after START (≥1).
- PC_W, 32: PC width.
- CNT_W, 32: width of every counter output.
- HALT_INSTR, 32'h0000000C: IF instruction word that ends the run (syscall).
- DRAIN_CYCLES, 4: cycles to keep counting after the halt is fetched (ID/EX/MEM/WB).
- LOOP_WINDOW, 8: consecutive cycles of unchanged PC with PCWrite=1 that count as a self-loop halt (≥2).
- MAX_CYCLES, 100000: cycle budget before timeout.

Ports:
- CLK  in  1  clock; all logic on rising edge.
- RESET  in  1  synchronous, active-low reset of this block.
- START  in  1  single-cycle request to begin a run.
- PC  in  PC_W  core fetch PC.
- PCWrite  in  1  core PC enable; 0 = stall.
- IF_Flush  in  1  core IF flush.
- IF_Instruction  in  32  fetched instruction.
- WB_Valid  in  1  register write retiring this cycle.
- WB_RD  in  5  writeback destination.
- WB_RD_DATA  in  32  writeback data.
- CORE_RESET  out  1  active-high reset to the pipeline top.
- BUSY  out  1  high in RST, RUN or DRAIN.
- DONE  out  1  high in DONE.
- TIMEOUT  out  1  run ended by budget.
- LOOP_HALT  out  1  run ended by self-loop.
- CYCLES, RETIRED, STALLS, FLUSHES  out  CNT_W each  run counters.
- TRACE_VALID  out  1  writeback trace strobe.
- TRACE_RD  out  5  trace destination.
- TRACE_DATA  out  32  trace data.

## Operation
- States: IDLE, RST, RUN, DRAIN, DONE.
- IDLE
  - CORE_RESET=1.
  - START → RST; clears all counters and flags.
- RST
  - CORE_RESET=1.
  - An internal counter runs RST_CYCLES cycles, then → RUN.
- RUN
  - CORE_RESET=0.
  - Each cycle: CYCLES+1; RETIRED+1 if WB_Valid; STALLS+1 if PCWrite=0; FLUSHES+1 if IF_Flush.
- Exits from RUN, in priority order:
  1. CYCLES==MAX_CYCLES-1 this cycle → DONE, TIMEOUT=1.
  2. IF_Instruction==HALT_INSTR and PCWrite=1 → DRAIN.
  3. Loop counter reaches LOOP_WINDOW → DONE, LOOP_HALT=1.
- Loop counter
  - Increments when PCWrite=1 and PC equals the previous cycle's PC.
  - Otherwise reloads to 1.
- DRAIN
  - Counting continues for DRAIN_CYCLES cycles, then → DONE.
  - Further halt words are ignored; timeout still applies and wins.
- DONE
  - Counters and flags frozen; CORE_RESET stays 0.
  - START → RST (new run).
- START is ignored in RST, RUN and DRAIN.
- Counters saturate at all-ones and never wrap.
- RESET low at any time, including mid-run:
  - next edge: state IDLE, CORE_RESET=1;
  - all counters, flags and trace outputs 0.

## Timing
- All outputs registered.
- After reset: CORE_RESET=1, everything else 0.
- START sampled at edge t:
  - BUSY=1 from t+1;
  - CORE_RESET falls at edge t+1+RST_CYCLES.
- Counter updates become visible one cycle after the sampled event.
- Halt fetched at edge h: DONE=1 at h+1+DRAIN_CYCLES.
- DONE/TIMEOUT/LOOP_HALT assert in the same cycle BUSY deasserts.

## Configuration
- Macro: PIPE_RUN_CTRL_TRACE_EN.
- Defined:
  - TRACE_VALID/TRACE_RD/TRACE_DATA are a one-cycle registered copy of WB_Valid/WB_RD/WB_RD_DATA.
  - Only active in RUN and DRAIN.
  - Events with WB_RD==0 are suppressed.
- Undefined:
  - trace outputs tied to 0 and the trace registers are not built;
  - RETIRED behaviour is unchanged.

## Test plan
- Reset low 2 cycles, START at cycle 3 with RST_CYCLES=2 → CORE_RESET=1 through cycle 5, 0 from cycle 6; BUSY=1 from cycle 4.
- Program of 10 register writes, then 0x0000000C → DONE exactly 5 cycles after the halt fetch; RETIRED=10; TIMEOUT=0.
- PCWrite forced 0 for 3 cycles and IF_Flush pulsed twice → STALLS=3, FLUSHES=2.
- PC held at 0x40 with PCWrite=1, LOOP_WINDOW=8 → LOOP_HALT=1, DONE after the 8th identical cycle.
- MAX_CYCLES=20, halt word arriving on cycle 20 of RUN → TIMEOUT=1, no DRAIN, CYCLES=20.
- RESET low mid-RUN → next edge IDLE, CORE_RESET=1, counters 0; START afterwards restarts cleanly.
- With PIPE_RUN_CTRL_TRACE_EN: write of 0xDEADBEEF to r5 → TRACE_VALID=1, TRACE_RD=5 the following cycle; write to r0 → no trace strobe.
